s2f_event_arbiter: RTL and testbench

Fast-domain scheduler for N slow-to-fast event channels. Each channel is a single-cycle fclk pulse already synchronized from the sclk domain. The block latches each event as pending and grants events round-robin, one at a time, to a shared downstream consumer through a valid/ready handshake. It counts events lost because the channel was already pending.

---
 rtl/s2f_event_arbiter.sv | 142 ++++++++++++++
 tb/tb_s2f_event_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2f_event_arbiter.sv
// Fast-domain round-robin scheduler for pre-synchronized event pulses.
// Latches events as pending, offers them one at a time over valid/ready and counts lost events.
module s2f_event_arbiter #(
  parameter  int N  = 4,
  parameter  int CW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          fclk,
  input  logic          reset_n,
  input  logic [N-1:0]  ev_in,
  output logic          out_valid,
  output logic [IW-1:0] out_id,
  input  logic          out_ready,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] drop_cnt,
  input  logic          drop_clr,
  output logic          busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;
  localparam int SW = CW + IW + 1;
  localparam logic [SW-1:0] DROP_MAX = SW'({CW{1'b1}});

  logic [0:0]    r_state;
  logic          r_out_valid;
  logic [IW-1:0] r_out_id;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_pending;
  logic [CW-1:0] r_drop_cnt;

  logic          w_hs;
  logic [N-1:0]  w_accept;
  logic [N-1:0]  w_pending_nxt;
  logic [N-1:0]  w_drop;
  logic [IW:0]   w_drop_n;
  logic [SW-1:0] w_drop_sum;
  logic [CW-1:0] w_drop_nxt;
  logic [IW-1:0] w_ptr_inc;
  logic [IW-1:0] w_sel;

  function automatic logic [IW:0] popcount(input logic [N-1:0] v);
    logic [IW:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{IW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // First set request at or after start, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] start);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k >= N) ? (int'(start) + k - N) : (int'(start) + k);
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next-state terms for pending bits, drop counting and pointer advance.
  always_comb begin
    w_hs = r_out_valid & out_ready;
    w_accept = '0;
    for (int i = 0; i < N; i++) begin
      w_accept[i] = w_hs & (r_out_id == IW'(i));
    end
    w_pending_nxt = ev_in | (r_pending & ~w_accept);
    w_drop        = ev_in & r_pending & ~w_accept;
    w_drop_n      = popcount(w_drop);
    w_drop_sum    = SW'(r_drop_cnt) + SW'(w_drop_n);
    if (drop_clr) begin
      w_drop_nxt = '0;
    end else if (w_drop_sum > DROP_MAX) begin
      w_drop_nxt = {CW{1'b1}};
    end else begin
      w_drop_nxt = w_drop_sum[CW-1:0];
    end
    if (r_out_id == IW'(N - 1)) begin
      w_ptr_inc = '0;
    end else begin
      w_ptr_inc = r_out_id + IW'(1);
    end
    w_sel = rr_pick(r_pending, r_ptr);
  end

  // Pending set and drop counter registers.
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Grant FSM: arbitrate from registered pending, then hold the offer until accepted.
  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_out_id    <= w_sel;
            r_out_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            r_ptr       <= w_ptr_inc;
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign pending   = r_pending;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = r_out_valid | (|r_pending);

endmodule

// File: tb/tb_s2f_event_arbiter.sv
// Directed bench for s2f_event_arbiter: main instance N=4/CW=8, second instance CW=2 for saturation.
module tb_s2f_event_arbiter;

  logic       fclk;
  logic       reset_n;
  logic [3:0] ev_in;
  logic       out_ready;
  logic       drop_clr;
  logic       out_valid;
  logic [1:0] out_id;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic       busy;

  logic [3:0] ev2;
  logic       ready2;
  logic       clr2;
  logic       valid2;
  logic [1:0] id2;
  logic [3:0] pend2;
  logic [1:0] drop2;
  logic       busy2;

  int n_cmp;
  int n_fail;

  s2f_event_arbiter #(.N(4), .CW(8)) u_dut (
    .fclk(fclk), .reset_n(reset_n), .ev_in(ev_in), .out_valid(out_valid), .out_id(out_id),
    .out_ready(out_ready), .pending(pending), .drop_cnt(drop_cnt), .drop_clr(drop_clr), .busy(busy)
  );

  s2f_event_arbiter #(.N(4), .CW(2)) u_dut2 (
    .fclk(fclk), .reset_n(reset_n), .ev_in(ev2), .out_valid(valid2), .out_id(id2),
    .out_ready(ready2), .pending(pend2), .drop_cnt(drop2), .drop_clr(clr2), .busy(busy2)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ev_in = 4'b0; out_ready = 1'b0; drop_clr = 1'b0;
    ev2 = 4'b0; ready2 = 1'b0; clr2 = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({out_valid, out_id, pending, drop_cnt, busy} !== 16'h0) begin
      $display("FAIL reset_state: got v=%b id=%0d p=%b d=%0d b=%b want all 0", out_valid, out_id, pending, drop_cnt, busy);
      n_fail++;
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, pending, busy} !== 6'h0) begin
      $display("FAIL reset_release: got v=%b p=%b b=%b want 0", out_valid, pending, busy);
      n_fail++;
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    ev_in = 4'b1000;
    tick();
    ev_in = 4'b0;
    n_cmp++;
    if (pending !== 4'b1000 || out_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL lat_pending: got p=%b v=%b b=%b want p=1000 v=0 b=1", pending, out_valid, busy);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd3) begin
      $display("FAIL lat_grant: got v=%b id=%0d want v=1 id=3", out_valid, out_id);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (pending !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL lat_accept: got p=%b v=%b b=%b want all 0", pending, out_valid, busy);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ids [2];
    out_ready = 1'b1;
    ev_in = 4'b1111;
    tick();
    ev_in = 4'b0;
    n_cmp++;
    if (pending !== 4'b1111 || out_valid !== 1'b0) begin
      $display("FAIL rr_latch: got p=%b v=%b want p=1111 v=0", pending, out_valid);
      n_fail++;
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== 2'(g)) begin
        $display("FAIL rr_grant%0d: got v=%b id=%0d want v=1 id=%0d", g, out_valid, out_id, g);
        n_fail++;
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        $display("FAIL rr_bubble%0d: got v=%b want 0", g, out_valid);
        n_fail++;
      end
    end
    exp_ids[0] = 2'd0;
    exp_ids[1] = 2'd3;
    ev_in = 4'b1001;
    tick();
    ev_in = 4'b0;
    for (int g = 0; g < 2; g++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== exp_ids[g]) begin
        $display("FAIL rr_wrap%0d: got v=%b id=%0d want v=1 id=%0d", g, out_valid, out_id, exp_ids[g]);
        n_fail++;
      end
      tick();
    end
    n_cmp++;
    if (pending !== 4'b0 || busy !== 1'b0) begin
      $display("FAIL rr_done: got p=%b b=%b want 0", pending, busy);
      n_fail++;
    end
  endtask

  task automatic test_stall_drops();
    out_ready = 1'b0;
    ev_in = 4'b0010;
    tick();
    ev_in = 4'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      $display("FAIL stall_grant: got v=%b id=%0d want v=1 id=1", out_valid, out_id);
      n_fail++;
    end
    for (int s = 0; s < 5; s++) begin
      ev_in = (s < 3) ? 4'b0010 : 4'b0100;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== 2'd1) begin
        $display("FAIL stall_hold%0d: got v=%b id=%0d want v=1 id=1", s, out_valid, out_id);
        n_fail++;
      end
    end
    ev_in = 4'b0;
    tick();
    n_cmp++;
    if (drop_cnt !== 8'd4 || pending !== 4'b0110) begin
      $display("FAIL stall_drops: got d=%0d p=%b want d=4 p=0110", drop_cnt, pending);
      n_fail++;
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (pending !== 4'b0100 || out_valid !== 1'b0) begin
      $display("FAIL stall_release: got p=%b v=%b want p=0100 v=0", pending, out_valid);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd2) begin
      $display("FAIL stall_next: got v=%b id=%0d want v=1 id=2", out_valid, out_id);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_same_cycle();
    out_ready = 1'b0;
    ev_in = 4'b0001;
    tick();
    ev_in = 4'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      $display("FAIL same_wrap_grant: got v=%b id=%0d want v=1 id=0", out_valid, out_id);
      n_fail++;
    end
    out_ready = 1'b1;
    ev_in = 4'b0001;
    tick();
    ev_in = 4'b0;
    n_cmp++;
    if (pending !== 4'b0001 || out_valid !== 1'b0 || drop_cnt !== 8'd4) begin
      $display("FAIL same_rearrive: got p=%b v=%b d=%0d want p=0001 v=0 d=4", pending, out_valid, drop_cnt);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      $display("FAIL same_regrant: got v=%b id=%0d want v=1 id=0", out_valid, out_id);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (pending !== 4'b0 || out_valid !== 1'b0) begin
      $display("FAIL same_done: got p=%b v=%b want 0", pending, out_valid);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    ready2 = 1'b0;
    ev2 = 4'b0001;
    tick();
    for (int s = 0; s < 5; s++) tick();
    n_cmp++;
    if (drop2 !== 2'd3) begin
      $display("FAIL sat_max: got %0d want 3", drop2);
      n_fail++;
    end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    n_cmp++;
    if (drop2 !== 2'd0) begin
      $display("FAIL sat_clear_wins: got %0d want 0", drop2);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (drop2 !== 2'd1) begin
      $display("FAIL sat_after_clear: got %0d want 1", drop2);
      n_fail++;
    end
    ev2 = 4'b0010;
    tick();
    ev2 = 4'b0011;
    tick();
    ev2 = 4'b0;
    n_cmp++;
    if (drop2 !== 2'd3 || pend2 !== 4'b0011) begin
      $display("FAIL sat_multi: got d=%0d p=%b want d=3 p=0011", drop2, pend2);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_offer();
    out_ready = 1'b0;
    ev_in = 4'b0100;
    tick();
    ev_in = 4'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || drop_cnt !== 8'd4) begin
      $display("FAIL rst_pre: got v=%b id=%0d d=%0d want v=1 id=2 d=4", out_valid, out_id, drop_cnt);
      n_fail++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_id, pending, drop_cnt, busy} !== 16'h0) begin
      $display("FAIL rst_async: got v=%b id=%0d p=%b d=%0d b=%b want all 0", out_valid, out_id, pending, drop_cnt, busy);
      n_fail++;
    end
    #2;
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    ev_in = 4'b0011;
    tick();
    ev_in = 4'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      $display("FAIL rst_ptr0: got v=%b id=%0d want v=1 id=0", out_valid, out_id);
      n_fail++;
    end
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      $display("FAIL rst_grant1: got v=%b id=%0d want v=1 id=1", out_valid, out_id);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_latency();
    test_round_robin();
    test_stall_drops();
    test_same_cycle();
    test_saturation();
    test_reset_mid_offer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
